lte_frame_sequencer: RTL

- Sequences the incoming 32-bit IQ sample stream into LTE OFDM symbols, aligned to the 10 ms frame sync pulse.
- Discards cyclic-prefix samples and forwards the FFT_SIZE useful samples of each symbol to the downstream FFT/demod path.
- Marks the first useful sample of each symbol on outUser and exports slot/symbol indices.
- Sits between the sample source and the FFT stage inside top.

---
 rtl/lte_frame_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lte_frame_sequencer.sv
// lte_frame_sequencer: aligns a 32-bit IQ stream to the 10 ms frame sync pulse,
// drops cyclic-prefix samples and forwards the FFT_SIZE useful samples of each
// OFDM symbol with a first-sample marker and slot/symbol indices.
// Optional statistics (frameCnt, resyncCnt) are built when SEQ_STATS_EN is defined.
//
// Handshake: an input sample is transferred on a clock edge where inValid && ready.
// ready is driven only from the current state (and outReady while forwarding useful
// samples), so it never depends on inValid. outValid is a one-cycle qualifier for
// outData; the block stalls the input rather than dropping output beats.
module lte_frame_sequencer #(
   parameter int INPUT_DATA_BITWIDTH = 32,
   parameter int FFT_SIZE            = 128,
   parameter int CP_FIRST            = 10,
   parameter int CP_OTHER            = 9,
   parameter int SYMBOLS_PER_SLOT    = 7,
   parameter int SLOTS_PER_FRAME     = 20
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           syncTo10ms,
   input  logic [INPUT_DATA_BITWIDTH-1:0] inData,
   input  logic                           inValid,
   output logic                           ready,
   input  logic                           outReady,
   output logic [INPUT_DATA_BITWIDTH-1:0] outData,
   output logic                           outValid,
   output logic                           outUser,
   output logic [2:0]                     symIdx,
   output logic [4:0]                     slotIdx,
   output logic                           resyncErr,
`ifdef SEQ_STATS_EN
   output logic [15:0]                    frameCnt,
   output logic [7:0]                     resyncCnt,
`endif
   output logic [1:0]                     fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CP     = 2'd1,
      S_USEFUL = 2'd2
   } state_t;

   localparam logic [7:0] CP_FIRST_LAST = 8'(CP_FIRST - 1);
   localparam logic [7:0] CP_OTHER_LAST = 8'(CP_OTHER - 1);
   localparam logic [7:0] FFT_LAST      = 8'(FFT_SIZE - 1);
   localparam logic [2:0] SYM_LAST      = 3'(SYMBOLS_PER_SLOT - 1);
   localparam logic [4:0] SLOT_LAST     = 5'(SLOTS_PER_FRAME - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] sym;
   logic [4:0] slot;

   logic       accept;
   logic       frame_start;
   logic       realign;
   logic [7:0] cp_last;

   assign fsm_state = state;

   // upstream may present a sample: never while unaligned, always while dropping CP
   always_comb begin
      ready = 1'b0;
      case (state)
         S_CP:     ready = 1'b1;
         S_USEFUL: ready = outReady;
         default:  ready = 1'b0;
      endcase
   end

   assign accept      = inValid && ready;
   // position where a frame sync is expected; a sync here changes nothing
   assign frame_start = (state == S_CP) && (slot == 5'd0) && (sym == 3'd0) && (cnt == 8'd0);
   assign realign     = syncTo10ms && !frame_start;
   assign cp_last     = (sym == 3'd0) ? CP_FIRST_LAST : CP_OTHER_LAST;

   // frame/slot/symbol sequencing with registered output stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         sym       <= 3'd0;
         slot      <= 5'd0;
         outData   <= '0;
         outValid  <= 1'b0;
         outUser   <= 1'b0;
         symIdx    <= 3'd0;
         slotIdx   <= 5'd0;
         resyncErr <= 1'b0;
      end else begin
         outValid  <= 1'b0;
         outUser   <= 1'b0;
         resyncErr <= 1'b0;
         if (realign) begin
            // a sync sample that arrives with data is frame sample 0 (first CP sample)
            resyncErr <= (state != S_IDLE);
            state     <= S_CP;
            slot      <= 5'd0;
            sym       <= 3'd0;
            cnt       <= inValid ? 8'd1 : 8'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_IDLE;
               end
               S_CP: begin
                  if (accept) begin
                     if (cnt == cp_last) begin
                        state <= S_USEFUL;
                        cnt   <= 8'd0;
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end
               end
               S_USEFUL: begin
                  if (accept) begin
                     outData  <= inData;
                     outValid <= 1'b1;
                     outUser  <= (cnt == 8'd0);
                     symIdx   <= sym;
                     slotIdx  <= slot;
                     if (cnt == FFT_LAST) begin
                        cnt   <= 8'd0;
                        state <= S_CP;
                        if (sym == SYM_LAST) begin
                           sym  <= 3'd0;
                           slot <= (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
                        end else begin
                           sym <= sym + 3'd1;
                        end
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef SEQ_STATS_EN
   logic frame_done;
   logic resync_evt;

   assign frame_done = !realign && (state == S_USEFUL) && accept && (cnt == FFT_LAST) &&
                       (sym == SYM_LAST) && (slot == SLOT_LAST);
   assign resync_evt = realign && (state != S_IDLE);

   // saturating completed-frame and resync counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         frameCnt  <= 16'd0;
         resyncCnt <= 8'd0;
      end else begin
         if (frame_done && (frameCnt != 16'hFFFF)) frameCnt <= frameCnt + 16'd1;
         if (resync_evt && (resyncCnt != 8'hFF))   resyncCnt <= resyncCnt + 8'd1;
      end
   end
`endif

endmodule
